note_loop_recorder: RTL and testbench
=====================================

Name: note_loop_recorder

Overview:
- Consumer-side counterpart to the auto-player's note stream. Captures a 4-bit note code on every quarter-beat tick into an internal buffer, then replays the captured sequence on the same tick grid.
- Sits between the keyboard/auto-player note mux and the tone generator. Lets a player record a phrase and loop it back.

Parameters:
- NOTE_W, 4, width of a note code.
- ADDR_W, 5, buffer address width; depth = 2**ADDR_W = 32 ticks.
- NONE_CODE, 4'd0, note code meaning silence; emitted whenever not playing.

Ports:
- CLK  input  1  system clock; all logic is on its rising edge.
- RESET  input  1  asynchronous, active-high reset.
- TICK  input  1  one-CLK-wide quarter-beat pulse, synchronous to CLK.
- NOTE_IN  input  NOTE_W  note currently sounding; sampled on TICK while recording.
- REC  input  1  level; request record mode.
- PLAY  input  1  level; request playback mode.
- CLEAR  input  1  one-cycle pulse; discard recording (honoured in IDLE only).
- NOTE_OUT  output  NOTE_W  registered playback note.
- LENGTH  output  ADDR_W+1  number of notes stored, 0..32.
- POS  output  ADDR_W  current write/read pointer.
- RECORDING  output  1  high in REC_S.
- PLAYING  output  1  high in PLAY_S.
- FULL  output  1  LENGTH == 2**ADDR_W.

Behaviour:
- Reset values: state IDLE, NOTE_OUT=NONE_CODE, LENGTH=0, POS=0, RECORDING=0, PLAYING=0, FULL=0. Buffer contents are not reset and are don't-care.
- States:
  - IDLE (2'd0)
  - REC_S (2'd1)
  - PLAY_S (2'd2)
  - 2'd3 is illegal and recovers to IDLE on the next edge.
- IDLE:
  - REC=1 -> REC_S, POS<=0, LENGTH<=0. REC has priority when REC and PLAY are both high.
  - Else PLAY=1 and LENGTH!=0 -> PLAY_S, POS<=0.
  - PLAY with LENGTH==0 is ignored.
  - CLEAR -> LENGTH<=0, POS<=0.
  - TICK is ignored in IDLE.
- A TICK in the same cycle as the IDLE->REC_S or IDLE->PLAY_S transition is not consumed. The first action occurs on the next TICK.
- REC_S:
  - Each TICK: buf[POS]<=NOTE_IN, POS<=POS+1, LENGTH<=LENGTH+1.
  - When that write makes LENGTH==32, go to IDLE in the same edge. FULL=1, POS wraps to 0.
  - REC=0 (no TICK) -> IDLE, LENGTH retained.
  - If REC=0 and TICK coincide, the note is written first, then IDLE.
  - CLEAR is ignored. NOTE_OUT stays NONE_CODE.
- PLAY_S:
  - Each TICK: NOTE_OUT<=buf[POS], POS<=POS+1. Latency is one CLK from TICK to NOTE_OUT.
  - Before the first TICK, NOTE_OUT=NONE_CODE.
  - On the TICK where POS==LENGTH (end of sequence), behaviour depends on NOTE_LOOP_REPEAT_EN (see Optional Feature).
  - PLAY=0 -> IDLE, NOTE_OUT<=NONE_CODE on that edge. A coincident TICK is discarded.
  - REC=1 while playing: no effect until IDLE is reached.
- NOTE_OUT holds its value between ticks. Rests (NONE_CODE) recorded in the buffer replay as rests.
- POS and LENGTH arithmetic is modulo-free except as stated. LENGTH saturates at 32 and never exceeds it.
- RESET asserted mid-record or mid-play forces all reset values immediately. The recording is lost because LENGTH=0.

Optional Feature:
- Macro: NOTE_LOOP_REPEAT_EN.
- Defined: at end of sequence (TICK with POS==LENGTH), POS wraps and NOTE_OUT<=buf[0], POS<=1. Playback loops indefinitely while PLAY=1.
- Undefined: at end of sequence, NOTE_OUT<=NONE_CODE and state -> IDLE. PLAYING drops on that edge; PLAY must fall and rise again to replay.

Test Plan:
- Record then play: RESET, REC=1, 5 TICKs with NOTE_IN=3,3,4,5,0, REC=0. Expect LENGTH=5. Then PLAY=1 and 6 TICKs: NOTE_OUT=3,3,4,5,0, then NONE_CODE with PLAYING=0 (macro off), or 3 (macro on).
- Full buffer: hold REC=1 for 34 TICKs with an incrementing pattern. Expect FULL=1 and RECORDING=0 after tick 32, LENGTH=32, ticks 33-34 ignored.
- Priority/empty: REC=PLAY=1 from IDLE -> REC_S. Separately, PLAY=1 with LENGTH=0 keeps IDLE and NOTE_OUT=NONE_CODE.
- Abort: PLAY=0 on the same cycle as the third TICK of playback -> NOTE_OUT=NONE_CODE next edge, state IDLE, LENGTH unchanged.
- TICK on entry: REC rises on the same cycle as TICK -> LENGTH stays 0. The next TICK records and gives LENGTH=1.
- RESET mid-play: assert RESET asynchronously between clock edges after 2 notes. Expect all outputs at reset values immediately and LENGTH=0.

Source files
------------

// File: rtl/note_loop_recorder.sv
// Note loop recorder: captures NOTE_IN on each TICK into a 32-entry buffer and replays it on the same tick grid.
// Optional build macro NOTE_LOOP_REPEAT_EN makes playback loop back to the first note instead of stopping.
module note_loop_recorder #(
  parameter int unsigned       NOTE_W    = 4,
  parameter int unsigned       ADDR_W    = 5,
  parameter logic [NOTE_W-1:0] NONE_CODE = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              TICK,
  input  logic [NOTE_W-1:0] NOTE_IN,
  input  logic              REC,
  input  logic              PLAY,
  input  logic              CLEAR,
  output logic [NOTE_W-1:0] NOTE_OUT,
  output logic [ADDR_W:0]   LENGTH,
  output logic [ADDR_W-1:0] POS,
  output logic              RECORDING,
  output logic              PLAYING,
  output logic              FULL
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REC_S  = 2'd1,
    PLAY_S = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    ptr_q, ptr_d;
  logic                hold_q, hold_d;
  logic                rec_q, play_q, full_q;
  logic                we_c;
  logic [NOTE_W-1:0]   rd_note_c;
  logic [NOTE_W-1:0]   mem [DEPTH];

  // Pointer carries one extra bit so a 32-note sequence can reach POS==LENGTH.
  assign rd_note_c = mem[ptr_q[ADDR_W-1:0]];

  // Next-state and datapath decode.
  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    len_d   = len_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    we_c    = 1'b0;
    if (!REC) hold_d = 1'b0;

    case (state_q)
      IDLE: begin
        note_d = NONE_CODE;
        // After an auto-stop on full, REC must fall before a new take starts.
        if (REC && !hold_q) begin
          state_d = REC_S;
          ptr_d   = '0;
          len_d   = '0;
        end else if (PLAY && (len_q != '0)) begin
          state_d = PLAY_S;
          ptr_d   = '0;
        end else if (CLEAR) begin
          len_d = '0;
          ptr_d = '0;
        end
      end

      REC_S: begin
        note_d = NONE_CODE;
        if (TICK) begin
          we_c  = 1'b1;
          ptr_d = ptr_q + LEN_W'(1);
          len_d = len_q + LEN_W'(1);
          if (len_d == LEN_FULL) begin
            state_d = IDLE;
            ptr_d   = '0;
            hold_d  = REC;
          end
        end
        if (!REC) state_d = IDLE;
      end

      PLAY_S: begin
        if (!PLAY) begin
          state_d = IDLE;
          note_d  = NONE_CODE;
        end else if (TICK) begin
          if (ptr_q == len_q) begin
`ifdef NOTE_LOOP_REPEAT_EN
            note_d = mem[0];
            ptr_d  = LEN_W'(1);
`else
            note_d  = NONE_CODE;
            state_d = IDLE;
`endif
          end else begin
            note_d = rd_note_c;
            ptr_d  = ptr_q + LEN_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        note_d  = NONE_CODE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      note_q  <= NONE_CODE;
      len_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= 1'b0;
      rec_q   <= 1'b0;
      play_q  <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      rec_q   <= (state_d == REC_S);
      play_q  <= (state_d == PLAY_S);
      full_q  <= (len_d == LEN_FULL);
    end
  end

  // Note buffer; contents are don't-care after reset.
  always_ff @(posedge CLK) begin
    if (we_c) mem[ptr_q[ADDR_W-1:0]] <= NOTE_IN;
  end

  assign NOTE_OUT  = note_q;
  assign LENGTH    = len_q;
  assign POS       = ptr_q[ADDR_W-1:0];
  assign RECORDING = rec_q;
  assign PLAYING   = play_q;
  assign FULL      = full_q;

endmodule

// File: tb/tb_note_loop_recorder.sv
// Bench for note_loop_recorder: table-driven vectors plus hand-written multi-cycle sequences, checked through a scoreboard queue.
module tb_note_loop_recorder;

  logic       CLK = 1'b0;
  logic       RESET, TICK, REC, PLAY, CLEAR;
  logic [3:0] NOTE_IN, NOTE_OUT;
  logic [5:0] LENGTH;
  logic [4:0] POS;
  logic       RECORDING, PLAYING, FULL;

  always #5 CLK = ~CLK;

  note_loop_recorder dut (
    .CLK(CLK), .RESET(RESET), .TICK(TICK), .NOTE_IN(NOTE_IN), .REC(REC),
    .PLAY(PLAY), .CLEAR(CLEAR), .NOTE_OUT(NOTE_OUT), .LENGTH(LENGTH),
    .POS(POS), .RECORDING(RECORDING), .PLAYING(PLAYING), .FULL(FULL)
  );

  typedef struct packed {
    logic [3:0] note;
    logic [5:0] len;
    logic [4:0] pos;
    logic       rec;
    logic       play;
    logic       full;
  } out_t;

  typedef struct packed {
    logic       rec;
    logic       play;
    logic       tick;
    logic       clear;
    logic [3:0] note_in;
    out_t       exp;
  } vec_t;

  out_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  vec_t tbl[21];

  function automatic out_t eo(input logic [3:0] n, input logic [5:0] l, input logic [4:0] p,
                              input logic r, input logic pl, input logic f);
    out_t o;
    o.note = n; o.len = l; o.pos = p; o.rec = r; o.play = pl; o.full = f;
    return o;
  endfunction

  function automatic vec_t mv(input logic r, input logic pl, input logic t, input logic c,
                              input logic [3:0] n, input out_t e);
    vec_t v;
    v.rec = r; v.play = pl; v.tick = t; v.clear = c; v.note_in = n; v.exp = e;
    return v;
  endfunction

  task automatic check_head(input string tag);
    out_t e, a;
    n_total++;
    if (sb_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      a = {NOTE_OUT, LENGTH, POS, RECORDING, PLAYING, FULL};
      if (a === e) n_pass++;
      else $display("FAIL %s: got note=%0d len=%0d pos=%0d rec=%0b play=%0b full=%0b, expected note=%0d len=%0d pos=%0d rec=%0b play=%0b full=%0b",
                    tag, a.note, a.len, a.pos, a.rec, a.play, a.full,
                    e.note, e.len, e.pos, e.rec, e.play, e.full);
    end
  endtask

  task automatic drive(input logic r, input logic pl, input logic t, input logic c,
                       input logic [3:0] n, input out_t e, input string tag);
    REC = r; PLAY = pl; TICK = t; CLEAR = c; NOTE_IN = n;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    check_head(tag);
  endtask

  initial begin
    RESET = 1'b1; TICK = 1'b0; REC = 1'b0; PLAY = 1'b0; CLEAR = 1'b0; NOTE_IN = 4'd0;
    repeat (2) @(posedge CLK);
    #1;
    sb_q.push_back(eo(0, 0, 0, 0, 0, 0));
    check_head("reset");
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    #1;

    // Record 3,3,4,5,0 then play back; then priority and empty-play cases.
    tbl[0]  = mv(1, 0, 0, 0, 0, eo(0, 0, 0, 1, 0, 0));
    tbl[1]  = mv(1, 0, 1, 0, 3, eo(0, 1, 1, 1, 0, 0));
    tbl[2]  = mv(1, 0, 0, 0, 9, eo(0, 1, 1, 1, 0, 0));
    tbl[3]  = mv(1, 0, 1, 0, 3, eo(0, 2, 2, 1, 0, 0));
    tbl[4]  = mv(1, 0, 1, 0, 4, eo(0, 3, 3, 1, 0, 0));
    tbl[5]  = mv(1, 0, 1, 0, 5, eo(0, 4, 4, 1, 0, 0));
    tbl[6]  = mv(1, 0, 1, 0, 0, eo(0, 5, 5, 1, 0, 0));
    tbl[7]  = mv(0, 0, 0, 0, 0, eo(0, 5, 5, 0, 0, 0));
    tbl[8]  = mv(0, 1, 0, 0, 0, eo(0, 5, 0, 0, 1, 0));
    tbl[9]  = mv(0, 1, 1, 0, 0, eo(3, 5, 1, 0, 1, 0));
    tbl[10] = mv(0, 1, 0, 0, 0, eo(3, 5, 1, 0, 1, 0));
    tbl[11] = mv(0, 1, 1, 0, 0, eo(3, 5, 2, 0, 1, 0));
    tbl[12] = mv(0, 1, 1, 0, 0, eo(4, 5, 3, 0, 1, 0));
    tbl[13] = mv(0, 1, 1, 0, 0, eo(5, 5, 4, 0, 1, 0));
    tbl[14] = mv(0, 1, 1, 0, 0, eo(0, 5, 5, 0, 1, 0));
`ifdef NOTE_LOOP_REPEAT_EN
    tbl[15] = mv(0, 1, 1, 0, 0, eo(3, 5, 1, 0, 1, 0));
    tbl[16] = mv(0, 0, 0, 0, 0, eo(0, 5, 1, 0, 0, 0));
`else
    tbl[15] = mv(0, 1, 1, 0, 0, eo(0, 5, 5, 0, 0, 0));
    tbl[16] = mv(0, 0, 0, 0, 0, eo(0, 5, 5, 0, 0, 0));
`endif
    tbl[17] = mv(1, 1, 0, 0, 0, eo(0, 0, 0, 1, 0, 0));
    tbl[18] = mv(0, 0, 0, 0, 0, eo(0, 0, 0, 0, 0, 0));
    tbl[19] = mv(0, 1, 1, 0, 0, eo(0, 0, 0, 0, 0, 0));
    tbl[20] = mv(0, 0, 0, 1, 0, eo(0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 21; i++)
      drive(tbl[i].rec, tbl[i].play, tbl[i].tick, tbl[i].clear, tbl[i].note_in, tbl[i].exp,
            $sformatf("vec%0d", i));

    // TICK coinciding with REC rising is not consumed.
    drive(1, 0, 1, 0, 7, eo(0, 0, 0, 1, 0, 0), "tick_entry");
    drive(1, 0, 1, 0, 9, eo(0, 1, 1, 1, 0, 0), "tick_entry_next");
    drive(0, 0, 0, 0, 0, eo(0, 1, 1, 0, 0, 0), "tick_entry_stop");

    // Fill the buffer with REC held; ticks past 32 are ignored.
    drive(1, 0, 0, 0, 0, eo(0, 0, 0, 1, 0, 0), "full_enter");
    for (int k = 0; k < 34; k++) begin
      if (k < 32)
        drive(1, 0, 1, 0, 4'(k), eo(0, 6'(k + 1), 5'((k + 1) % 32), k < 31, 0, k == 31),
              $sformatf("full_tick%0d", k + 1));
      else
        drive(1, 0, 1, 0, 4'(k), eo(0, 32, 0, 0, 0, 1), $sformatf("full_tick%0d", k + 1));
    end
    drive(0, 0, 0, 0, 0, eo(0, 32, 0, 0, 0, 1), "full_release");

    // Play all 32 notes and hit end of sequence.
    drive(0, 1, 0, 0, 0, eo(0, 32, 0, 0, 1, 1), "p32_enter");
    for (int k = 0; k < 32; k++)
      drive(0, 1, 1, 0, 0, eo(4'(k), 32, 5'((k + 1) % 32), 0, 1, 1), $sformatf("p32_tick%0d", k));
`ifdef NOTE_LOOP_REPEAT_EN
    drive(0, 1, 1, 0, 0, eo(0, 32, 1, 0, 1, 1), "p32_end");
    drive(0, 0, 0, 0, 0, eo(0, 32, 1, 0, 0, 1), "p32_stop");
`else
    drive(0, 1, 1, 0, 0, eo(0, 32, 0, 0, 0, 1), "p32_end");
    drive(0, 0, 0, 0, 0, eo(0, 32, 0, 0, 0, 1), "p32_stop");
`endif

    // Abort: PLAY falls with the third tick.
    drive(0, 1, 0, 0, 0, eo(0, 32, 0, 0, 1, 1), "abort_enter");
    drive(0, 1, 1, 0, 0, eo(0, 32, 1, 0, 1, 1), "abort_t1");
    drive(0, 1, 1, 0, 0, eo(1, 32, 2, 0, 1, 1), "abort_t2");
    drive(0, 0, 1, 0, 0, eo(0, 32, 2, 0, 0, 1), "abort_t3");

    // Asynchronous reset mid-play.
    drive(0, 1, 0, 0, 0, eo(0, 32, 0, 0, 1, 1), "rst_enter");
    drive(0, 1, 1, 0, 0, eo(0, 32, 1, 0, 1, 1), "rst_t1");
    drive(0, 1, 1, 0, 0, eo(1, 32, 2, 0, 1, 1), "rst_t2");
    #3 RESET = 1'b1;
    #1;
    sb_q.push_back(eo(0, 0, 0, 0, 0, 0));
    check_head("rst_async");
    TICK = 1'b0; PLAY = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    drive(0, 1, 0, 0, 0, eo(0, 0, 0, 0, 0, 0), "post_rst_play_empty");

    // REC drop coinciding with TICK writes first; CLEAR honoured only in IDLE.
    drive(1, 0, 0, 0, 0, eo(0, 0, 0, 1, 0, 0), "clr_rec");
    drive(1, 0, 1, 1, 6, eo(0, 1, 1, 1, 0, 0), "clr_ignored_in_rec");
    drive(0, 0, 1, 0, 2, eo(0, 2, 2, 0, 0, 0), "rec_drop_with_tick");
    drive(0, 0, 0, 1, 0, eo(0, 0, 0, 0, 0, 0), "clear_idle");
    drive(0, 1, 0, 0, 0, eo(0, 0, 0, 0, 0, 0), "play_after_clear");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
